// File: rtl/fact_pkg.sv
// fact_pkg: shared state encoding and default widths for the factorial sequencer.
//   state_e   : controller FSM states (IDLE, MULT, DONE)
//   N_W_DEF   : default operand/counter width
//   P_W_DEF   : default product/result width
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_W_DEF = 8;
    localparam int P_W_DEF = 32;

endpackage

// File: rtl/fact_seq_ctrl_if.sv
// fact_seq_ctrl_if: request/result handshake bundle between a source/consumer and the controller.
//   in_valid/in_ready/n          : operand handshake
//   out_valid/out_ready          : result handshake
//   result/ovf                   : n! truncated to P_W bits and overflow flag
//   busy                         : controller is iterating the product
//   master : source/consumer side; slave : controller side
interface fact_seq_ctrl_if
    import fact_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int P_W = P_W_DEF
) ();

    logic           in_valid;
    logic           in_ready;
    logic [N_W-1:0] n;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] result;
    logic           ovf;
    logic           busy;

    modport master (
        output in_valid, n, out_ready,
        input  in_ready, out_valid, result, ovf, busy
    );

    modport slave (
        input  in_valid, n, out_ready,
        output in_ready, out_valid, result, ovf, busy
    );

endinterface

// File: rtl/fact_dcnt.sv
// fact_dcnt: N_W-bit loadable down-counter.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   en         : enable; with load_cnt loads d, without it decrements
//   load_cnt   : select load versus decrement when enabled
//   d          : load value
//   q          : current count
module fact_dcnt
    import fact_pkg::*;
#(
    parameter int N_W = N_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           load_cnt,
    input  logic [N_W-1:0] d,
    output logic [N_W-1:0] q
);

    logic [N_W-1:0] cnt_q;
    logic [N_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = load_cnt ? d : cnt_q - N_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/fact_seq_ctrl.sv
// fact_seq_ctrl: accepts n, iterates prod <= prod*count down to count 1, returns n! with overflow flag.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any operation)
//   bus        : slave side of fact_seq_ctrl_if (operand handshake, result handshake, busy)
module fact_seq_ctrl
    import fact_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int P_W = P_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    fact_seq_ctrl_if.slave   bus
);

    state_e         state_q, state_d;
    logic [P_W-1:0] prod_q, prod_d;
    logic           ovf_q, ovf_d;
    logic           en, load_cnt;
    logic [N_W-1:0] count;
    logic [P_W+N_W-1:0] mul_w;

    fact_dcnt #(.N_W(N_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load_cnt (load_cnt),
        .d        (bus.n),
        .q        (count)
    );

    // Full-width product so bits lost to truncation can be folded into ovf.
    assign mul_w = {{N_W{1'b0}}, prod_q} * {{P_W{1'b0}}, count};

    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        ovf_d    = ovf_q;
        en       = 1'b0;
        load_cnt = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                en       = 1'b1;
                load_cnt = 1'b1;
                prod_d   = P_W'(1);
                ovf_d    = 1'b0;
                state_d  = MULT;
            end
            // Stop at count<=1 so the counter never wraps below 1 (or leaves 0 alone).
            MULT: if (count <= N_W'(1)) begin
                state_d = DONE;
            end else begin
                en     = 1'b1;
                prod_d = mul_w[P_W-1:0];
                ovf_d  = ovf_q | (|mul_w[P_W+N_W-1:P_W]);
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset interval.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == MULT);
    assign bus.result    = prod_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// tb_fact_seq_ctrl: directed scoreboard bench for fact_seq_ctrl.
module tb_fact_seq_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    typedef struct {
        logic [31:0] r;
        logic        o;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fact_seq_ctrl_if #(.N_W(8), .P_W(32)) bus ();

    fact_seq_ctrl #(.N_W(8), .P_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int nv, output logic [31:0] r, output logic o);
        longint p;
        longint w;
        p = 1;
        o = 1'b0;
        for (int c = nv; c >= 2; c--) begin
            w = p * longint'(c);
            if ((w >> 32) != 0) o = 1'b1;
            p = w & 64'hFFFF_FFFF;
        end
        r = p[31:0];
    endfunction

    // Called at a negedge with the controller idle; returns one cycle after the acceptance edge.
    task automatic start(input int nv, input logic [31:0] er, input logic eo, input bit push);
        exp_t e;
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.n        = nv[7:0];
        if (push) begin
            e.r   = er;
            e.o   = eo;
            e.lat = (nv < 1) ? 1 : nv;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic wait_out(output int lat);
        bit ok;
        ok  = 0;
        lat = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("out_valid_timeout", 0, 1);
    endtask

    task automatic check_out(input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check("result", bus.result, e.r);
            check("ovf", bus.ovf, e.o);
            check("latency", lat, e.lat);
        end
    endtask

    task automatic run(input int nv, input logic [31:0] er, input logic eo);
        int lat;
        start(nv, er, eo, 1);
        wait_out(lat);
        check_out(lat);
        @(negedge clk);
        check("out_valid_single_cycle", bus.out_valid, 0);
        check("in_ready_after_consume", bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] mr;
        logic        mo;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.n         = '0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        check("rst_ovf", bus.ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(5, 32'd120, 1'b0);
        run(0, 32'd1, 1'b0);
        run(1, 32'd1, 1'b0);
        run(12, 32'h1C8C_FC00, 1'b0);
        run(13, 32'h7328_CC00, 1'b1);

        // Back-pressure: result held, in_valid pulses ignored while DONE.
        bus.out_ready = 1'b0;
        start(4, 32'd24, 1'b0, 1);
        wait_out(lat);
        check_out(lat);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_result", bus.result, 24);
            check("bp_ovf", bus.ovf, 0);
            check("bp_in_ready", bus.in_ready, 0);
            bus.in_valid = i[0];
            bus.n        = 8'd7;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", bus.out_valid, 0);
        check("bp_release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("bp_no_stray_accept", bus.busy, 0);

        // Reset during the 4th MULT cycle of n=10.
        start(10, 32'd0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_result_cleared", bus.result, 0);
        check("abort_out_valid_idle", bus.out_valid, 0);
        run(3, 32'd6, 1'b0);

        // Largest operand: counter stops at 1, product checked against the model.
        model(255, mr, mo);
        start(255, mr, mo, 1);
        wait_out(lat);
        check("n255_count_end", dut.count, 1);
        check_out(lat);
        @(negedge clk);
        check("n255_consumed", bus.out_valid, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fact_seq_ctrl.md
Name: fact_seq_ctrl

Overview:
Sequencing controller for the factorial datapath. Accepts an operand n over a valid/ready handshake and loads it into a loadable down-counter. It then iterates the product register (prod <= prod * count) once per cycle while decrementing the counter, and presents the result over a valid/ready output handshake. It sits between the request source and the result consumer, and owns the counter's en/load_cnt controls.

Parameters:
N_W, 8, operand/counter width in bits
P_W, 32, product/result width in bits (P_W >= N_W)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand n is valid
in_ready  out  1  controller can accept an operand
n  in  N_W  operand, unsigned
out_valid  out  1  result is valid
out_ready  in  1  consumer accepts the result
result  out  P_W  n! truncated to P_W bits
ovf  out  1  true product exceeded P_W bits; valid with out_valid
busy  out  1  high in MULT

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, prod=0, ovf=0, out_valid=0, busy=0, in_ready=0 while rst_n low, in_ready=1 from the first cycle after release.
- States: IDLE, MULT, DONE (encoded in the package enum).
- IDLE: in_ready=1. On in_valid&&in_ready: counter loads n (en=1, load_cnt=1), prod<=1, ovf<=0, next=MULT. n is sampled only on this edge.
- MULT: in_ready=0, busy=1. Each cycle:
  - If count<=1: next=DONE. prod and counter are unchanged.
  - Else: prod <= (prod*count)[P_W-1:0]; ovf <= ovf | (|(prod*count)[P_W+N_W-1:P_W]); counter decrements (en=1, load_cnt=0).
- Product arithmetic: full P_W+N_W-bit unsigned product, low P_W bits retained. ovf is sticky for the whole operation.
- DONE: out_valid=1. result=prod and ovf are held stable until out_ready. On out_valid&&out_ready: next=IDLE, out_valid drops on that edge. Back-pressure of any length holds DONE.
- in_ready is 0 in MULT and DONE; no new operand is accepted until the result has been consumed.
- Latency, from the acceptance edge to the first cycle out_valid=1: max(n,1) cycles.
  - n=0 and n=1 give result=1, latency 1.
  - n=5: 4 multiply cycles (counts 5,4,3,2) plus 1 terminate cycle = 5.
- Counter never wraps: decrement occurs only when count>=2, so count never goes below 1 after load (or stays 0 for n=0).
- result equals prod in all states; consumers qualify it with out_valid only.
- Simultaneous events: in_valid in MULT/DONE is ignored (not consumed). out_ready outside DONE is ignored.
- Reset mid-operation: the operation is aborted immediately (async). The pending result is discarded, no out_valid is produced, and the controller resumes in IDLE.

Decomposition:
- Package fact_pkg: state enum (IDLE, MULT, DONE), default widths N_W_DEF=8, P_W_DEF=32.
- One sub-module: fact_dcnt, the N_W-bit loadable down-counter.
  - Ports: clk, rst_n, en, load_cnt, d, q.
  - Async active-low reset to 0.
  - en&&load_cnt loads d; en&&!load_cnt decrements; otherwise holds.
- The FSM, product register and overflow logic stay in fact_seq_ctrl.

Test Plan:
- Reset release, then n=5 with in_valid=1 for one cycle, out_ready=1 -> out_valid rises 5 cycles after acceptance, result=120, ovf=0, single-cycle out_valid, in_ready back to 1 next cycle.
- n=0, then n=1 back-to-back -> each gives result=1, ovf=0, latency 1; second operand accepted the cycle after the first result is consumed.
- n=12 -> result=479001600 (0x1C8CFC00), ovf=0. Then n=13 -> result=1932053504 (0x7328CC00), ovf=1.
- n=4 with out_ready=0 for 10 cycles after out_valid -> result=24 and ovf held stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> handshake completes, IDLE.
- n=10, assert rst_n=0 during the 4th MULT cycle -> out_valid=0 and busy=0 immediately. After release, in_ready=1 and no stale result; a fresh n=3 gives result=6.
- n=255 with N_W=8, P_W=32 -> completes in 255 cycles, ovf=1, no counter wrap (count ends at 1), result equals the truncated product computed by the reference model.
